// File: rtl/decode_stage_fwd.sv
// RV32I decode stage: operand resolution with prioritised forwarding, load-use
// hazard detection and a registered ID/EX slot with valid/ready handshakes.
module decode_stage_fwd #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  output logic [4:0]              rs1_addr,
  output logic [4:0]              rs2_addr,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    ex_load,
  input  logic [4:0]              ex_rd,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_instr,
  output logic [XLEN-1:0]         out_opA,
  output logic [XLEN-1:0]         out_opB,
  output logic [XLEN-1:0]         out_imm,
  output logic [6:0]              out_opcode,
  output logic [2:0]              out_funct3,
  output logic [6:0]              out_funct7,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [4:0]              out_rd,
  output logic                    out_wr_rd,
  output logic                    out_illegal,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILLEGAL
  } op_class_e;

  op_class_e        op_class;
  logic [6:0]       dec_opcode;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic [4:0]       dec_rd;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  dec_imm;
  logic             uses_rs1;
  logic             uses_rs2;
  logic             dec_wr_rd;
  logic             dec_illegal;
  logic [XLEN-1:0]  opa_res;
  logic [XLEN-1:0]  opb_res;
  logic             hazard;
  logic             accept;

  logic             valid_d,   valid_q;
  logic [XLEN-1:0]  pc_d,      pc_q;
  logic [31:0]      instr_d,   instr_q;
  logic [XLEN-1:0]  opa_d,     opa_q;
  logic [XLEN-1:0]  opb_d,     opb_q;
  logic [XLEN-1:0]  imm_d,     imm_q;
  logic             wr_rd_d,   wr_rd_q;
  logic             illegal_d, illegal_q;
  logic [CNT_W-1:0] stall_d,   stall_q;

  assign dec_opcode = in_instr[6:0];
  assign dec_rs1    = in_instr[19:15];
  assign dec_rs2    = in_instr[24:20];
  assign dec_rd     = in_instr[11:7];
  assign rs1_addr   = dec_rs1;
  assign rs2_addr   = dec_rs2;

  always_comb begin
    op_class = CL_ILLEGAL;
    case (dec_opcode)
      OP_R:      op_class = CL_R;
      OP_I:      op_class = CL_I;
      OP_LOAD:   op_class = CL_LOAD;
      OP_STORE:  op_class = CL_STORE;
      OP_BRANCH: op_class = CL_BRANCH;
      OP_JAL:    op_class = CL_JAL;
      OP_JALR:   op_class = CL_JALR;
      OP_LUI:    op_class = CL_LUI;
      OP_AUIPC:  op_class = CL_AUIPC;
      default:   op_class = CL_ILLEGAL;
    endcase
  end

  always_comb begin
    imm32 = 32'd0;
    case (op_class)
      CL_I, CL_LOAD, CL_JALR:
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      CL_STORE:
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      CL_BRANCH:
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                 in_instr[30:25], in_instr[11:8], 1'b0};
      CL_LUI, CL_AUIPC:
        imm32 = {in_instr[31:12], 12'd0};
      CL_JAL:
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                 in_instr[20], in_instr[30:21], 1'b0};
      default:
        imm32 = 32'd0;
    endcase
  end

  assign dec_imm = XLEN'($signed(imm32));

  // Illegal opcodes read no registers, so they can never raise a load-use stall.
  always_comb begin
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    dec_wr_rd   = 1'b0;
    dec_illegal = 1'b0;
    case (op_class)
      CL_R:                uses_rs1 = 1'b1;
      CL_I, CL_LOAD:       uses_rs1 = 1'b1;
      CL_STORE, CL_BRANCH: uses_rs1 = 1'b1;
      CL_JALR:             uses_rs1 = 1'b1;
      default:             uses_rs1 = 1'b0;
    endcase
    uses_rs2 = (op_class == CL_R) || (op_class == CL_STORE) || (op_class == CL_BRANCH);
    case (op_class)
      CL_R, CL_I, CL_LOAD, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC:
        dec_wr_rd = (dec_rd != 5'd0);
      CL_ILLEGAL:
        dec_illegal = 1'b1;
      default:
        dec_wr_rd = 1'b0;
    endcase
  end

  // Walk from the oldest source to the youngest so the lowest index wins.
  always_comb begin
    opa_res = rf_rdata1;
    opb_res = rf_rdata2;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[5*i +: 5] == dec_rs1))
        opa_res = fwd_data[XLEN*i +: XLEN];
      if (fwd_valid[i] && (fwd_rd[5*i +: 5] == dec_rs2))
        opb_res = fwd_data[XLEN*i +: XLEN];
    end
    if (dec_rs1 == 5'd0)
      opa_res = '0;
    if (dec_rs2 == 5'd0)
      opb_res = '0;
  end

  assign hazard = in_valid && ex_load && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (ex_rd == dec_rs1)) || (uses_rs2 && (ex_rd == dec_rs2)));

  assign in_ready = flush || (!hazard && (!valid_q || out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    imm_d     = imm_q;
    wr_rd_d   = wr_rd_q;
    illegal_d = illegal_q;
    stall_d   = stall_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      pc_d      = in_pc;
      instr_d   = in_instr;
      opa_d     = opa_res;
      opb_d     = opb_res;
      imm_d     = dec_imm;
      wr_rd_d   = dec_wr_rd;
      illegal_d = dec_illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    if (hazard && !flush && (stall_q != STALL_MAX))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      imm_q     <= '0;
      wr_rd_q   <= 1'b0;
      illegal_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      imm_q     <= imm_d;
      wr_rd_q   <= wr_rd_d;
      illegal_q <= illegal_d;
      stall_q   <= stall_d;
    end
  end

  // Register fields come straight out of the captured word.
  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_instr   = instr_q;
  assign out_opA     = opa_q;
  assign out_opB     = opb_q;
  assign out_imm     = imm_q;
  assign out_opcode  = instr_q[6:0];
  assign out_funct3  = instr_q[14:12];
  assign out_funct7  = instr_q[31:25];
  assign out_rs1     = instr_q[19:15];
  assign out_rs2     = instr_q[24:20];
  assign out_rd      = instr_q[11:7];
  assign out_wr_rd   = wr_rd_q;
  assign out_illegal = illegal_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Bench for decode_stage_fwd: directed scenarios with literal expectations,
// then randomized traffic against a behavioural model of the stage.
module tb_decode_stage_fwd;
  localparam int XLEN = 32;
  localparam int NUM_FWD = 2;
  localparam int CNT_W = 16;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUI = 8, C_ILL = 9;

  logic clock = 1'b0;
  logic reset;
  logic in_valid, in_ready;
  logic [31:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic [4:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic [NUM_FWD-1:0] fwd_valid;
  logic [5*NUM_FWD-1:0] fwd_rd;
  logic [XLEN*NUM_FWD-1:0] fwd_data;
  logic ex_load;
  logic [4:0] ex_rd;
  logic flush;
  logic out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_opA, out_opB, out_imm;
  logic [31:0] out_instr;
  logic [6:0] out_opcode, out_funct7;
  logic [2:0] out_funct3;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic out_wr_rd, out_illegal;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // model of the ID/EX slot
  logic m_valid = 1'b0;
  logic [31:0] m_pc = '0, m_instr = '0, m_opa = '0, m_opb = '0, m_imm = '0;
  logic m_wr = 1'b0, m_ill = 1'b0;
  int unsigned m_stall = 0;

  decode_stage_fwd #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .ex_load(ex_load), .ex_rd(ex_rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_opA(out_opA), .out_opB(out_opB), .out_imm(out_imm),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_wr_rd(out_wr_rd),
    .out_illegal(out_illegal), .stall_cnt(stall_cnt));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int cls(input logic [6:0] op);
    case (op)
      7'h33: return C_R;
      7'h13: return C_I;
      7'h03: return C_LD;
      7'h23: return C_ST;
      7'h63: return C_BR;
      7'h6F: return C_JAL;
      7'h67: return C_JALR;
      7'h37: return C_LUI;
      7'h17: return C_AUI;
      default: return C_ILL;
    endcase
  endfunction

  // immediates built arithmetically from the signed instruction word
  function automatic logic [31:0] mdl_imm(input logic [31:0] ins);
    int s;
    s = $signed(ins);
    case (cls(ins[6:0]))
      C_I, C_LD, C_JALR: return 32'(s >>> 20);
      C_ST:  return 32'((s >>> 25) * 32 + int'(ins[11:7]));
      C_BR:  return 32'((s >>> 31) * 4096 + int'(ins[7]) * 2048 +
                        int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
      C_LUI, C_AUI: return ins & 32'hFFFF_F000;
      C_JAL: return 32'((s >>> 31) * (1 << 20) + int'(ins[19:12]) * 4096 +
                        int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mdl_opnd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    for (int i = 0; i < NUM_FWD; i++)
      if (fwd_valid[i] && fwd_rd[5*i +: 5] == rs) return fwd_data[32*i +: 32];
    return rf;
  endfunction

  function automatic logic mdl_hazard();
    int c;
    logic u1, u2;
    c = cls(in_instr[6:0]);
    u1 = (c == C_R || c == C_I || c == C_LD || c == C_ST || c == C_BR || c == C_JALR);
    u2 = (c == C_R || c == C_ST || c == C_BR);
    return in_valid && ex_load && ex_rd != 0 &&
           ((u1 && ex_rd == in_instr[19:15]) || (u2 && ex_rd == in_instr[24:20]));
  endfunction

  task automatic check_outs();
    check("out_valid", out_valid, m_valid);
    check("stall_cnt", stall_cnt, m_stall);
    if (m_valid) begin
      check("out_pc", out_pc, m_pc);
      check("out_instr", out_instr, m_instr);
      check("out_opA", out_opA, m_opa);
      check("out_opB", out_opB, m_opb);
      check("out_imm", out_imm, m_imm);
      check("out_opcode", out_opcode, m_instr[6:0]);
      check("out_funct3", out_funct3, m_instr[14:12]);
      check("out_funct7", out_funct7, m_instr[31:25]);
      check("out_rs1", out_rs1, m_instr[19:15]);
      check("out_rs2", out_rs2, m_instr[24:20]);
      check("out_rd", out_rd, m_instr[11:7]);
      check("out_wr_rd", out_wr_rd, m_wr);
      check("out_illegal", out_illegal, m_ill);
    end
  endtask

  // Inputs are already driven; check comb outputs, advance model and DUT one edge.
  task automatic cycle();
    logic haz, rdy, n_valid, n_wr, n_ill;
    logic [31:0] n_pc, n_instr, n_opa, n_opb, n_imm;
    int unsigned n_stall;
    int c;
    #1;
    haz = mdl_hazard();
    rdy = flush || (!haz && (!m_valid || out_ready));
    check("in_ready", in_ready, rdy);
    check("rs1_addr", rs1_addr, in_instr[19:15]);
    check("rs2_addr", rs2_addr, in_instr[24:20]);
    n_valid = m_valid; n_pc = m_pc; n_instr = m_instr; n_opa = m_opa;
    n_opb = m_opb; n_imm = m_imm; n_wr = m_wr; n_ill = m_ill; n_stall = m_stall;
    if (flush) n_valid = 1'b0;
    else if (in_valid && rdy) begin
      c = cls(in_instr[6:0]);
      n_valid = 1'b1;
      n_pc = in_pc;
      n_instr = in_instr;
      n_opa = mdl_opnd(in_instr[19:15], rf_rdata1);
      n_opb = mdl_opnd(in_instr[24:20], rf_rdata2);
      n_imm = mdl_imm(in_instr);
      n_ill = (c == C_ILL);
      n_wr = (c != C_ILL && c != C_ST && c != C_BR) && in_instr[11:7] != 0;
    end else if (out_ready) n_valid = 1'b0;
    if (haz && !flush && m_stall < (1 << CNT_W) - 1) n_stall = m_stall + 1;
    @(posedge clock);
    #1;
    m_valid = n_valid; m_pc = n_pc; m_instr = n_instr; m_opa = n_opa; m_opb = n_opb;
    m_imm = n_imm; m_wr = n_wr; m_ill = n_ill; m_stall = n_stall;
    check_outs();
  endtask

  task automatic peek_ready(input string name, input logic exp);
    #1;
    check(name, in_ready, exp);
  endtask

  task automatic quiet();
    in_valid = 0; flush = 0; ex_load = 0; ex_rd = 0; fwd_valid = '0;
    fwd_rd = '0; fwd_data = '0; rf_rdata1 = 32'h99; rf_rdata2 = 32'h77; out_ready = 1;
  endtask

  task automatic send(input logic [31:0] ins);
    in_valid = 1;
    in_instr = ins;
    in_pc = in_pc + 4;
    cycle();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0] ops [10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    ins = $urandom;
    ins[6:0] = ops[$urandom_range(0, 9)];
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    ins[11:7] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    reset = 1; in_pc = 32'h1000; in_instr = 0;
    quiet();
    repeat (2) @(posedge clock);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset stall_cnt", stall_cnt, 0);
    check("reset out_instr", out_instr, 0);
    check("reset out_illegal", out_illegal, 0);
    check("reset out_imm", out_imm, 0);
    reset = 0;

    // back-to-back ADDI x1,x0,5 then ADD x2,x1,x1 with forwarding
    send(32'h0050_0093);
    check("addi valid", out_valid, 1);
    check("addi imm", out_imm, 32'd5);
    check("addi wr_rd", out_wr_rd, 1);
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd1}; fwd_data = {32'h0, 32'h5};
    send(32'h0010_8133);
    check("add valid", out_valid, 1);
    check("add opA", out_opA, 32'd5);
    check("add opB", out_opB, 32'd5);

    // forwarding priority on x3
    fwd_valid = 2'b11; fwd_rd = {5'd3, 5'd3}; fwd_data = {32'hBB, 32'hAA}; rf_rdata1 = 32'hCC;
    send(32'h0001_8213);
    check("fwd0 wins", out_opA, 32'hAA);
    fwd_valid = 2'b10;
    send(32'h0001_8213);
    check("fwd1 used", out_opA, 32'hBB);
    fwd_valid = 2'b00;
    send(32'h0001_8213);
    check("rf used", out_opA, 32'hCC);
    fwd_valid = 2'b11; fwd_rd = '0;
    send(32'h0000_0213);
    check("x0 is zero", out_opA, 32'h0);

    // load-use
    quiet();
    ex_load = 1; ex_rd = 5; in_valid = 1; in_instr = 32'h0002_8333;
    peek_ready("load-use ready", 0);
    cycle();
    check("load-use bubble", out_valid, 0);
    check("load-use stall", stall_cnt, 1);
    ex_load = 0;
    cycle();
    check("load-use accept", out_instr, 32'h0002_8333);
    check("load-use stall hold", stall_cnt, 1);
    ex_load = 1; in_instr = 32'h0002_8337;
    peek_ready("lui no stall", 1);
    cycle();
    check("lui imm", out_imm, 32'h0002_8000);
    check("lui stall", stall_cnt, 1);
    ex_load = 0;

    // immediates and illegal
    send(32'hFE11_2E23);
    check("sw imm", out_imm, 32'hFFFF_FFFC);
    send(32'hFE00_0CE3);
    check("beq imm", out_imm, 32'hFFFF_FFF8);
    send(32'h0000_037F);
    check("illegal flag", out_illegal, 1);
    check("illegal wr_rd", out_wr_rd, 0);

    // backpressure
    out_ready = 0; in_instr = 32'h0010_0093;
    for (int k = 0; k < 3; k++) begin
      peek_ready("bp ready", 0);
      cycle();
      check("bp hold", out_instr, 32'h0000_037F);
    end
    out_ready = 1;
    peek_ready("bp release", 1);
    cycle();
    check("bp capture", out_instr, 32'h0010_0093);

    // flush drops incoming instruction
    flush = 1; in_instr = 32'h0070_0393;
    peek_ready("flush ready", 1);
    cycle();
    check("flush valid", out_valid, 0);
    flush = 0; in_valid = 0;
    cycle();
    check("flush not seen", out_valid, 0);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      in_valid = ($urandom_range(0, 9) < 8);
      in_instr = rand_instr();
      in_pc = $urandom;
      rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      fwd_valid = NUM_FWD'($urandom);
      for (int i = 0; i < NUM_FWD; i++) begin
        fwd_rd[5*i +: 5] = 5'($urandom_range(0, 7));
        fwd_data[32*i +: 32] = $urandom;
      end
      ex_load = ($urandom_range(0, 9) < 3);
      ex_rd = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    // asynchronous reset mid-stream
    check("stall before reset nonzero", (stall_cnt != 0), 1);
    #2;
    reset = 1;
    #1;
    check("async reset valid", out_valid, 0);
    check("async reset stall", stall_cnt, 0);
    check("async reset instr", out_instr, 0);
    m_valid = 0; m_stall = 0; m_pc = 0; m_instr = 0; m_opa = 0; m_opb = 0;
    m_imm = 0; m_wr = 0; m_ill = 0;
    #1;
    reset = 0;
    quiet();
    send(32'h0050_0093);
    check("post-reset imm", out_imm, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/decode_stage_fwd.md
Name: decode_stage_fwd

Overview:
- Parametrised successor to the single-bypass ID stage: decodes one RV32I instruction per cycle, resolves operands from the register file plus NUM_FWD prioritised forwarding sources, and detects load-use hazards.
- Holds the result in a registered ID/EX slot with valid/ready handshakes on both sides, plus flush and a saturating stall counter.
- Sits between the IF/ID register and EX.

Parameters:
XLEN, 32, datapath width (instruction is always 32 bits)
NUM_FWD, 2, number of forwarding sources; index 0 = youngest = highest priority
CNT_W, 16, width of stall counter

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  stage accepts this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of instruction
rs1_addr  out  5  comb regfile read address = in_instr[19:15]
rs2_addr  out  5  comb regfile read address = in_instr[24:20]
rf_rdata1  in  XLEN  regfile data for rs1_addr (same cycle)
rf_rdata2  in  XLEN  regfile data for rs2_addr
fwd_valid  in  NUM_FWD  source i holds a result to be written
fwd_rd  in  5*NUM_FWD  destination of source i, slice [5i+4:5i]
fwd_data  in  XLEN*NUM_FWD  value of source i
ex_load  in  1  instruction in EX is a load (data not yet available)
ex_rd  in  5  rd of that load
flush  in  1  kill contents and incoming instruction
out_valid  out  1  ID/EX slot valid
out_ready  in  1  EX consumes slot
out_pc, out_instr  out  XLEN, 32  registered copies
out_opA, out_opB  out  XLEN  resolved rs1/rs2 values
out_imm  out  XLEN  sign-extended immediate
out_opcode  out  7  opcode
out_funct3, out_funct7  out  3, 7  function fields
out_rs1, out_rs2, out_rd  out  5 each  register fields
out_wr_rd  out  1  instruction writes a nonzero rd
out_illegal  out  1  opcode not in the supported set
stall_cnt  out  CNT_W  load-use stall cycles

Behaviour:
- Reset (async): out_valid=0, every out_* payload=0, stall_cnt=0; in_ready is combinational and follows the rules below.
- Opcode classes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode sets out_illegal=1; it is still passed through with out_wr_rd=0.
- Immediate by class:
  - I/LOAD/JALR: I-type.
  - STORE: S-type.
  - BRANCH: B-type, bit0=0.
  - LUI/AUIPC: instr[31:12]<<12.
  - JAL: J-type, bit0=0.
  - R/illegal: 0.
  - All immediates are sign-extended to XLEN.
- Register use: uses_rs1 = all classes except LUI/AUIPC/JAL. uses_rs2 = R/STORE/BRANCH.
- out_wr_rd = (R|I|LOAD|JAL|JALR|LUI|AUIPC) && rd!=0.
- Operand resolution (comb, per operand):
  - rs==0 gives 0.
  - Otherwise, the lowest index i with fwd_valid[i] && fwd_rd[i]==rs supplies fwd_data[i].
  - Otherwise the operand is rf_rdata.
  - An unused operand is still resolved; its value is don't-care for correctness but must follow these rules.
- hazard = in_valid && ex_load && ex_rd!=0 && ((uses_rs1 && ex_rd==rs1) || (uses_rs2 && ex_rd==rs2)).
- in_ready = flush || (!hazard && (!out_valid || out_ready)).
- Slot update, per clock edge, in priority order:
  1. flush: out_valid<=0; the incoming instruction is dropped even when in_valid=1; payload may hold.
  2. in_valid && in_ready: capture all decoded fields; out_valid<=1.
  3. out_ready (including a hazard cycle): out_valid<=0, which inserts a bubble.
  4. Else: hold out_valid and the full payload unchanged (backpressure).
- Latency: 1 cycle from acceptance to out_valid. Throughput is 1 per cycle when out_ready=1 and there is no hazard.
- stall_cnt increments on every cycle with hazard && !flush and saturates at 2^CNT_W-1. It is cleared only by reset.
- rs1_addr/rs2_addr are driven from in_instr regardless of in_valid.

Test Plan:
- Back-to-back: ADDI x1,x0,5 (0x00500093) then ADD x2,x1,x1 with fwd0 valid rd=1 data=5, out_ready=1 -> second cycle out_opA=out_opB=5; out_valid is continuous; out_imm=5 for the ADDI.
- Forward priority: fwd0 rd=3 data=0xAA, fwd1 rd=3 data=0xBB, rf=0xCC, instr reads x3 -> opA=0xAA. Drop fwd0 -> 0xBB. Drop both -> 0xCC. With rs1=x0 and all sources matching 0 -> opA=0.
- Load-use: ex_load=1 ex_rd=5, in_instr ADD x6,x5,x0 -> in_ready=0, next out_valid=0, stall_cnt=1. Deassert ex_load -> accepted; stall_cnt stays 1. LUI x6 with the same ex_rd -> no stall.
- Backpressure: out_ready=0 with slot valid -> in_ready=0 and payload is stable for 3 cycles. Raise out_ready -> next instruction captured on that edge.
- Flush/reset: flush with in_valid=1 -> in_ready=1, out_valid=0 next cycle, instruction not seen. Assert reset mid-stream asynchronously -> out_valid=0 and stall_cnt=0 immediately.
- Immediates and illegal: SW (0xFE112E23) -> out_imm=0xFFFFFFFC; BEQ offset -8 -> 0xFFFFFFF8; opcode 0x7F -> out_illegal=1, out_wr_rd=0.
